llc_bus_responder: RTL

- Bus-side agent at the far end of the LLC's system-bus interface.
- Accepts one bus transaction at a time from the LLC: READ, WRITE, INVALIDATE or RWIM.
- Resolves the snoop phase on behalf of the other caches, models owner-writeback and memory latency, and returns a response carrying the snoop result the LLC consumes.
- Keeps per-operation bus statistics for the testbench.

---
 rtl/LLC_defs.sv | 48 ++++
 rtl/llc_bus_latency_ctr.sv | 27 ++
 rtl/llc_bus_responder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/LLC_defs.sv
// Shared LLC bus definitions: bus operations, snoop results, responder FSM
// states and the address-to-snoop mapping used by both the LLC and the responder.
package LLC_defs;

    typedef enum logic [2:0] {
        NOBUSOP    = 3'd0,
        READ       = 3'd1,
        WRITE      = 3'd2,
        INVALIDATE = 3'd3,
        RWIM       = 3'd4
    } busOperation;

    typedef enum logic [1:0] {
        HIT      = 2'd0,
        HITM     = 2'd1,
        NOHIT    = 2'd2,
        NORESULT = 2'd3
    } snoopResults;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SNOOP    = 3'd1,
        OWNER_WB = 3'd2,
        MEM      = 3'd3,
        RESP     = 3'd4
    } resp_state_t;

    // Address low bits that select the modelled snoop outcome of other caches
    localparam logic [1:0] SNOOP_HIT_SEL  = 2'b00;
    localparam logic [1:0] SNOOP_HITM_SEL = 2'b10;

    // Snoop result the other caches return for a given operation and address select
    function automatic snoopResults snoopOutcome(input busOperation op, input logic [1:0] sel);
        snoopResults result;
        result = NORESULT;
        if (op == READ || op == RWIM) begin
            if (sel == SNOOP_HIT_SEL) begin
                result = HIT;
            end else if (sel == SNOOP_HITM_SEL) begin
                result = HITM;
            end else begin
                result = NOHIT;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/llc_bus_latency_ctr.sv
// Loadable 8-bit down-counter with a zero flag. Shared by the owner-writeback
// and memory phases of the bus responder to time their latency.
module llc_bus_latency_ctr (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_loadValue,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [7:0] r_count;

    // Load takes priority over decrement; the count parks at zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (i_dec && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/llc_bus_responder.sv
// Bus-side responder at the far end of the LLC system-bus interface. Accepts one
// transaction at a time, resolves the snoop phase, models owner writeback and
// memory latency, returns a response and keeps per-operation statistics.
// Optional macro LLC_BUS_TRACE_EN prints one trace line per response handshake.
module llc_bus_responder
    import LLC_defs::*;
#(
    parameter int ADDR_W      = 32,
    parameter int MEM_LATENCY = 4,
    parameter int WB_LATENCY  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  busOperation       req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output busOperation       resp_op,
    output logic [ADDR_W-1:0] resp_addr,
    output snoopResults       resp_snoop,
    output logic              busy,
    output logic              err,
    input  logic              stats_clr,
    output logic [31:0]       cnt_rd,
    output logic [31:0]       cnt_wr,
    output logic [31:0]       cnt_inv,
    output logic [31:0]       cnt_rwim,
    output logic [31:0]       cnt_hitm
);

    localparam logic [7:0] MEM_LOAD = 8'(MEM_LATENCY - 1);
    localparam logic [7:0] WB_LOAD  = 8'(WB_LATENCY - 1);

    resp_state_t       r_state;
    logic              r_reqReady;
    logic              r_respValid;
    logic              r_busy;
    busOperation       r_op;
    logic [ADDR_W-1:0] r_addr;
    snoopResults       r_snoop;
    logic              r_err;
    logic [31:0]       r_cntRd;
    logic [31:0]       r_cntWr;
    logic [31:0]       r_cntInv;
    logic [31:0]       r_cntRwim;
    logic [31:0]       r_cntHitm;

    snoopResults       w_snoopNow;
    logic              w_ctrLoad;
    logic [7:0]        w_ctrLoadValue;
    logic              w_ctrDec;
    logic              w_ctrZero;
    logic              w_complete;

    assign w_snoopNow = snoopOutcome(r_op, r_addr[1:0]);
    assign w_complete = (r_state == RESP) && resp_ready;

    llc_bus_latency_ctr u_latencyCtr (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_load      (w_ctrLoad),
        .i_loadValue (w_ctrLoadValue),
        .i_dec       (w_ctrDec),
        .o_zero      (w_ctrZero)
    );

    // Load the shared counter on entry to each timed phase, count down inside it
    always_comb begin
        w_ctrLoad      = 1'b0;
        w_ctrLoadValue = MEM_LOAD;
        w_ctrDec       = 1'b0;
        unique case (r_state)
            SNOOP: begin
                w_ctrLoad      = 1'b1;
                w_ctrLoadValue = (w_snoopNow == HITM) ? WB_LOAD : MEM_LOAD;
            end
            OWNER_WB: begin
                if (w_ctrZero) begin
                    w_ctrLoad      = 1'b1;
                    w_ctrLoadValue = MEM_LOAD;
                end else begin
                    w_ctrDec = 1'b1;
                end
            end
            MEM: begin
                w_ctrDec = 1'b1;
            end
            default: begin
                w_ctrLoad = 1'b0;
            end
        endcase
    end

    // Transaction FSM with registered handshake, busy and response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_reqReady  <= 1'b1;
            r_respValid <= 1'b0;
            r_busy      <= 1'b0;
            r_op        <= NOBUSOP;
            r_addr      <= '0;
            r_snoop     <= NORESULT;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_op       <= req_op;
                        r_addr     <= req_addr;
                        r_snoop    <= NORESULT;
                        r_reqReady <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= SNOOP;
                    end
                end
                SNOOP: begin
                    r_snoop <= w_snoopNow;
                    if (w_snoopNow == HITM) begin
                        r_state <= OWNER_WB;
                    end else if (r_op == READ || r_op == RWIM || r_op == WRITE) begin
                        r_state <= MEM;
                    end else begin
                        r_respValid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                OWNER_WB: begin
                    if (w_ctrZero) begin
                        r_state <= MEM;
                    end
                end
                MEM: begin
                    if (w_ctrZero) begin
                        r_respValid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_respValid <= 1'b0;
                        r_reqReady  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_respValid <= 1'b0;
                    r_reqReady  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // Statistics and sticky error; a clear beats any same-edge update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err     <= 1'b0;
            r_cntRd   <= 32'd0;
            r_cntWr   <= 32'd0;
            r_cntInv  <= 32'd0;
            r_cntRwim <= 32'd0;
            r_cntHitm <= 32'd0;
        end else if (stats_clr) begin
            r_err     <= 1'b0;
            r_cntRd   <= 32'd0;
            r_cntWr   <= 32'd0;
            r_cntInv  <= 32'd0;
            r_cntRwim <= 32'd0;
            r_cntHitm <= 32'd0;
        end else begin
            if (r_state == SNOOP && r_op == NOBUSOP) begin
                r_err <= 1'b1;
            end
            if (w_complete) begin
                unique case (r_op)
                    READ:       r_cntRd   <= r_cntRd + 32'd1;
                    WRITE:      r_cntWr   <= r_cntWr + 32'd1;
                    INVALIDATE: r_cntInv  <= r_cntInv + 32'd1;
                    RWIM:       r_cntRwim <= r_cntRwim + 32'd1;
                    default:    r_cntRd   <= r_cntRd;
                endcase
                if (r_snoop == HITM) begin
                    r_cntHitm <= r_cntHitm + 32'd1;
                end
            end
        end
    end

`ifdef LLC_BUS_TRACE_EN
    logic [31:0] r_cycleCount;
    logic [31:0] r_acceptCycle;

    // Free-running cycle count and the cycle each transaction was accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycleCount  <= 32'd0;
            r_acceptCycle <= 32'd0;
        end else begin
            r_cycleCount <= r_cycleCount + 32'd1;
            if (r_state == IDLE && req_valid) begin
                r_acceptCycle <= r_cycleCount;
            end
        end
    end

    // One trace line per response handshake
    always_ff @(posedge clk) begin
        if (reset && w_complete) begin
            $display("[TRACE] t=%0t op=%s addr=%h snoop=%s cycles=%0d",
                     $time, r_op.name(), r_addr, r_snoop.name(), r_cycleCount - r_acceptCycle);
        end
    end
`endif

    assign req_ready  = r_reqReady;
    assign resp_valid = r_respValid;
    assign busy       = r_busy;
    assign resp_op    = r_op;
    assign resp_addr  = r_addr;
    assign resp_snoop = r_snoop;
    assign err        = r_err;
    assign cnt_rd     = r_cntRd;
    assign cnt_wr     = r_cntWr;
    assign cnt_inv    = r_cntInv;
    assign cnt_rwim   = r_cntRwim;
    assign cnt_hitm   = r_cntHitm;

endmodule
